// File: rtl/ysyx_24100005_mem_arbiter.sv
// Two-master memory arbiter: shares one memory port between the IFU (read-only) and the LSU,
// one transaction at a time, round-robin on conflict, with a response timeout.
module ysyx_24100005_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err,

    output logic                busy
);

    localparam int               MASK_W     = DATA_W / 8;
    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              grant_id;
    logic [CNT_W-1:0]  wait_cnt;

    logic              pick_lsu;
    logic              accept;
    logic              timed_out;
    logic              finish;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // On a conflict the master that did not win last time gets the port.
    always_comb begin
        pick_lsu = lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid) begin
            pick_lsu = ~last_grant;
        end
    end

    // Readies are held low while reset is asserted so nothing handshakes during reset.
    assign ifu_req_ready = (state == IDLE) && !rst && ifu_req_valid && !pick_lsu;
    assign lsu_req_ready = (state == IDLE) && !rst && lsu_req_valid && pick_lsu;
    assign accept        = ifu_req_ready || lsu_req_ready;

    // A real response wins over a timeout landing on the same cycle.
    assign timed_out  = TIMEOUT_EN && (wait_cnt == CNT_LIMIT);
    assign finish     = (state == WAIT) && (mem_resp_valid || timed_out);
    assign resp_rdata = mem_resp_valid ? mem_rdata : '0;
    assign resp_err   = mem_resp_valid ? mem_resp_err : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant_id       <= 1'b0;
            wait_cnt       <= '0;
            busy           <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= ISSUE;
                        busy          <= 1'b1;
                        mem_req_valid <= 1'b1;
                        grant_id      <= lsu_req_ready;
                        last_grant    <= lsu_req_ready;
                        if (lsu_req_ready) begin
                            mem_addr  <= lsu_addr;
                            mem_wen   <= lsu_wen;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                        end else begin
                            mem_addr  <= ifu_addr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wmask <= {MASK_W{1'b0}};
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                        wait_cnt      <= '0;
                    end
                end
                WAIT: begin
                    if (finish) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (grant_id) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= resp_rdata;
                            lsu_resp_err   <= resp_err;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= resp_rdata;
                            ifu_resp_err   <= resp_err;
                        end
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ysyx_24100005_mem_arbiter.md
# ysyx_24100005_mem_arbiter

Two-master memory arbiter for the NPC core. It shares the single DPI-backed memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It runs one transaction at a time and uses round-robin on conflicts. A response timeout turns a hung memory access into an error response. It sits between the IFU/LSU and the memory-access wrapper that calls `npcmem_read` / `npcmem_write`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` = mask width
- `TIMEOUT`, 255, max cycles in WAIT before forced error response; 0 disables the timeout
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `ifu_req_valid`  in  1  fetch request
- `ifu_req_ready`  out  1  fetch request accepted this cycle
- `ifu_addr`  in  ADDR_W  fetch address
- `ifu_resp_valid`  out  1  one-cycle response pulse
- `ifu_rdata`  out  DATA_W  fetched instruction
- `ifu_resp_err`  out  1  error, qualified by `ifu_resp_valid`
- `lsu_req_valid`, `lsu_req_ready`, `lsu_addr`: as IFU
- `lsu_wen`  in  1  1 = store, 0 = load
- `lsu_wdata`  in  DATA_W  store data
- `lsu_wmask`  in  DATA_W/8  byte enables
- `lsu_resp_valid`, `lsu_rdata`, `lsu_resp_err`: as IFU
- `mem_req_valid`  out  1  downstream request
- `mem_req_ready`  in  1  downstream accepts request
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`  out  downstream request fields
- `mem_resp_valid`  in  1  downstream response
- `mem_rdata`  in  DATA_W  downstream read data
- `mem_resp_err`  in  1  downstream error
- `busy`  out  1  state != IDLE

## Operation
- **States:** IDLE, ISSUE, WAIT. Also held: `last_grant` (0 = IFU, 1 = LSU), a timeout counter, and latched request fields.
- **IDLE grant (combinational):**
  - Only one valid: grant that master.
  - Both valid: grant the master ≠ `last_grant`.
  - Granted master sees `req_ready = 1`. The other sees 0. In non-IDLE states both readies are 0.
- **On `valid && ready`:**
  - Latch addr/wen/wdata/wmask and the grant id.
  - Update `last_grant`.
  - Go to ISSUE.
  - IFU requests latch wen=0, wdata=0, wmask=0.
- **ISSUE:**
  - `mem_req_valid = 1` with the latched fields, held stable until `mem_req_ready`.
  - On `mem_req_ready`: go to WAIT and clear the counter.
- **WAIT:**
  - On `mem_resp_valid`: register `mem_rdata` / `mem_resp_err` into the granted master's `rdata` / `resp_err`, pulse its `resp_valid` for one cycle on the next cycle, and go to IDLE.
  - Otherwise increment the counter.
  - When `TIMEOUT != 0` and counter == `TIMEOUT`: pulse `resp_valid` with `resp_err = 1`, `rdata = 0`, and go to IDLE.
- **Stray input:** `mem_resp_valid` in IDLE/ISSUE is discarded (late response after a timeout).
- **Response capture:** masters must accept responses unconditionally (no resp_ready). `rdata` holds its value between pulses. A store's rdata is whatever memory returns.
- **Non-granted master:** its outputs never pulse.

## Timing
- **Reset values:**
  - All `*_req_ready`, `*_resp_valid`, `*_resp_err`, `mem_req_valid`, `busy`: 0.
  - `*_rdata`, `mem_addr`, `mem_wdata`, `mem_wmask`, `mem_wen`: 0.
  - State IDLE, `last_grant` = LSU (IFU wins the first conflict), counter 0.
- **Reset mid-transaction:** abandoned, no response emitted. `mem_req_valid` drops asynchronously.
- **Minimum latency** (`mem_req_ready` = 1, zero-delay memory):
  - accept at cycle 0;
  - `mem_req_valid` at cycle 1;
  - WAIT at cycle 2, with `mem_resp_valid` sampled;
  - master `resp_valid` at cycle 3.
- **Back-to-back:** the `resp_valid` cycle is an IDLE cycle and can accept the next request, so peak throughput is 1 transaction per 3 cycles.
- **Timeout:** with no response, the error pulse occurs `TIMEOUT + 1` cycles after entering WAIT.
- **Simultaneous events:**
  - `mem_req_ready` during ISSUE's first cycle is honoured; no stall cycle is added.
  - New requests arriving during a transaction wait; requester must hold valid/fields stable.
- **Counter width:** `$clog2(TIMEOUT + 1)`, at least 1 bit; it saturates and never wraps.

## Test plan
- **Single IFU read:** reset release, `ifu_req_valid` addr 0x80000000, memory ready=1 returns 0x00000413 next cycle -> `ifu_req_ready` at cycle 0, `mem_addr` = 0x80000000 with `mem_wen` = 0 at cycle 1, `ifu_resp_valid` with `ifu_rdata` = 0x00000413 at cycle 3, `lsu_resp_valid` stays 0.
- **LSU store:** addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, `mem_req_ready` held 0 for 4 cycles -> `mem_*` fields stable across all 5 ISSUE cycles, `lsu_resp_valid` 2 cycles after the handshake.
- **Conflict:** both valid continuously for 4 transactions -> grants IFU, LSU, IFU, LSU; no master starves.
- **Timeout:** `TIMEOUT` = 4, memory never responds -> `lsu_resp_valid` with `lsu_resp_err` = 1 and `lsu_rdata` = 0 exactly 5 cycles after entering WAIT. A later stray `mem_resp_valid` produces no pulse.
- **Memory error:** `mem_resp_err` = 1 with `mem_rdata` = 0x12345678 -> granted master sees err = 1 and rdata = 0x12345678.
- **Async reset mid-WAIT:** assert `rst` between clock edges -> `busy`, `mem_req_valid` and readies are 0 immediately. No response pulse after release. The next conflict grants IFU first.
